ac_fan_driver: RTL and testbench
================================

# ac_fan_driver

Actuator-side driver that consumes the AC controller's `fan_speed` / `fan_heat` commands and turns them into physical drive signals. It produces a fan PWM output, ramping the fan one speed step at a time so the motor never sees abrupt changes. It also switches the compressor with an anti-short-cycle lockout. It sits between the AC control block and the fan/compressor power stage, and runs on the same clock and reset.

## Interface

Parameters:

- `PWM_PERIOD`, 100: clock cycles per PWM period; must be a multiple of 4 and ≥ 4.
- `RAMP_PERIODS`, 4: PWM periods per single speed step while ramping; ≥ 1.
- `MIN_OFF_CYCLES`, 200: minimum compressor off time in cycles after switching off; ≥ 1.

Ports:

- `clk`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fan_speed`  in  3  commanded speed: 0 = off, 1..4; 5..7 are clamped to 4.
- `fan_heat`  in  8  commanded outlet temperature setpoint.
- `temperature`  in  7  measured room temperature.
- `fan_pwm`  out  1  registered fan PWM drive.
- `speed_actual`  out  3  currently applied speed step, 0..4.
- `ramping`  out  1  high while `speed_actual` ≠ clamped target.
- `compressor_on`  out  1  registered compressor enable.

## Operation

- Reset values, applied asynchronously while `reset`=0:
  - `fan_pwm`=0, `speed_actual`=0, `compressor_on`=0.
  - `pwm_cnt`=0, `ramp_cnt`=0, `lock_cnt`=0.
  - FSM in `OFF`.
  - `ramping` is combinational: `target` ≠ 0.
- Target: `target` = min(`fan_speed`, 4), evaluated every cycle.
- PWM counter:
  - `pwm_cnt` free-runs 0..`PWM_PERIOD`-1, then wraps to 0.
  - "Period end" = the cycle where `pwm_cnt` == `PWM_PERIOD`-1.
- Duty:
  - `duty` = `speed_actual` × (`PWM_PERIOD`/4); width is $clog2(`PWM_PERIOD`+1).
  - `fan_pwm` <= (`pwm_cnt` < `duty`).
  - This gives 0/25/50/75/100 % duty.
- Ramp:
  - While `speed_actual` == `target`, `ramp_cnt` is held at 0.
  - Otherwise `ramp_cnt` increments at each period end.
  - At a period end with `ramp_cnt` == `RAMP_PERIODS`-1: `ramp_cnt` <= 0, and `speed_actual` steps ±1 toward `target`.
  - Direction is re-evaluated at every step. A reversal mid-ramp does not clear `ramp_cnt`.
  - If `target` becomes equal to `speed_actual`, `ramp_cnt` clears on the next cycle.
  - `speed_actual` changes only at a period end, so no partial or glitch pulses occur.
- Compressor request: `req` = (`speed_actual` ≠ 0) && (`fan_heat` < {1'b0,`temperature`}). This is an unsigned 8-bit compare.
- Compressor FSM:
  - `OFF`, `compressor_on`=0: if `req`, go to `RUN` and set `compressor_on` <= 1.
  - `RUN`, `compressor_on`=1: if !`req`, go to `LOCKOUT`, set `compressor_on` <= 0, and load `lock_cnt` <= `MIN_OFF_CYCLES`-1.
  - `LOCKOUT`, `compressor_on`=0: `lock_cnt` decrements each cycle; `req` is ignored. When `lock_cnt` == 0, go to `OFF`.
- Simultaneous events: a speed step and a compressor transition on the same edge are independent. `req` is evaluated on pre-edge `speed_actual`.

## Timing

- `fan_pwm` at edge t+1 reflects `pwm_cnt` and `speed_actual` at edge t. Each PWM period therefore starts with `fan_pwm` updated one cycle after `pwm_cnt` wraps to 0.
- Ramp timing:
  - First speed step happens at the `RAMP_PERIODS`-th period end after `target` first differs.
  - Each further step follows every `RAMP_PERIODS`×`PWM_PERIOD` cycles.
  - A full 0→4 ramp takes 4×`RAMP_PERIODS` periods.
- Compressor latency:
  - `OFF`→`RUN`: `compressor_on` rises 1 cycle after `req` goes high.
  - `RUN`→off: `compressor_on` falls 1 cycle after `req` goes low.
  - After a fall, `compressor_on` is low for at least `MIN_OFF_CYCLES`+1 cycles before it can rise again.
- Reset mid-operation: all outputs go to their reset values immediately, with no clock required. After release, normal counting restarts from 0.

## Test plan

- Defaults; reset, then `fan_speed`=4 -> `ramping`=1, `speed_actual` = 1, 2, 3, 4 at period ends 4, 8, 12, 16 (edges ~400/800/1200/1600); `fan_pwm` is then constantly 1 and `ramping`=0.
- `speed_actual` settled at 2 -> each 100-cycle period has `fan_pwm` high for exactly 50 cycles, then low for 50.
- `fan_speed`=7 -> clamps to 4. From 4, set `fan_speed`=0 -> steps down one level per 4 periods, finally `fan_pwm`=0. Reverse to 3 mid-ramp at level 2 -> next step goes to 3 and stops.
- `speed_actual`=3, `temperature`=30, `fan_heat`=25 -> `compressor_on`=1 one cycle later. Set `fan_heat`=40 -> `compressor_on` falls one cycle later. Set `fan_heat`=25 on the next cycle -> `compressor_on` stays 0 for ≥201 cycles, then rises.
- With `compressor_on`=1, ramp `fan_speed` to 0 -> `compressor_on` drops the cycle after `speed_actual` reaches 0.
- Assert `reset` mid-ramp at level 2 and mid-`LOCKOUT` -> all outputs are 0 asynchronously. After release with `fan_speed`=1, the first step occurs at period end 4.

Source files
------------

// File: rtl/ac_fan_driver_if.sv
// rtl/ac_fan_driver_if.sv - command/drive signal bundle between AC controller and fan driver
interface ac_fan_driver_if;
  logic [2:0] fan_speed;
  logic [7:0] fan_heat;
  logic [6:0] temperature;
  logic       fan_pwm;
  logic [2:0] speed_actual;
  logic       ramping;
  logic       compressor_on;

  modport master (
    output fan_speed, fan_heat, temperature,
    input  fan_pwm, speed_actual, ramping, compressor_on
  );

  modport slave (
    input  fan_speed, fan_heat, temperature,
    output fan_pwm, speed_actual, ramping, compressor_on
  );
endinterface

// File: rtl/ac_fan_driver.sv
// rtl/ac_fan_driver.sv - fan PWM speed-ramp driver with compressor anti-short-cycle lockout
module ac_fan_driver #(
  parameter int PWM_PERIOD     = 100,
  parameter int RAMP_PERIODS   = 4,
  parameter int MIN_OFF_CYCLES = 200
) (
  input logic            clk,
  input logic            reset,
  ac_fan_driver_if.slave bus
);
  localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam int LW = (MIN_OFF_CYCLES > 1) ? $clog2(MIN_OFF_CYCLES) : 1;

  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);
  localparam logic [DW-1:0] QUARTER   = DW'(PWM_PERIOD / 4);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_PERIODS - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(MIN_OFF_CYCLES - 1);

  typedef enum logic [1:0] {OFF, RUN, LOCKOUT} comp_state_t;

  comp_state_t   state, state_next;
  logic [PW-1:0] pwm_cnt;
  logic [RW-1:0] ramp_cnt;
  logic [LW-1:0] lock_cnt, lock_next;
  logic [2:0]    speed_actual, target;
  logic [DW-1:0] duty;
  logic          fan_pwm, compressor_on, compressor_next;
  logic          period_end, req;

  assign target     = (bus.fan_speed > 3'd4) ? 3'd4 : bus.fan_speed;
  assign period_end = (pwm_cnt == PWM_LAST);
  assign duty       = DW'(speed_actual) * QUARTER;
  assign req        = (speed_actual != 3'd0) && (bus.fan_heat < {1'b0, bus.temperature});

  assign bus.fan_pwm       = fan_pwm;
  assign bus.speed_actual  = speed_actual;
  assign bus.ramping       = (speed_actual != target);
  assign bus.compressor_on = compressor_on;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= '0;
      fan_pwm <= 1'b0;
    end else begin
      pwm_cnt <= period_end ? '0 : pwm_cnt + PW'(1);
      fan_pwm <= (DW'(pwm_cnt) < duty);
    end
  end

  // Speed only moves at a period end, so every PWM period is a whole pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ramp_cnt     <= '0;
      speed_actual <= 3'd0;
    end else if (speed_actual == target) begin
      ramp_cnt <= '0;
    end else if (period_end) begin
      if (ramp_cnt == RAMP_LAST) begin
        ramp_cnt     <= '0;
        speed_actual <= (target > speed_actual) ? speed_actual + 3'd1 : speed_actual - 3'd1;
      end else begin
        ramp_cnt <= ramp_cnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= OFF;
      lock_cnt      <= '0;
      compressor_on <= 1'b0;
    end else begin
      state         <= state_next;
      lock_cnt      <= lock_next;
      compressor_on <= compressor_next;
    end
  end

  // Requests are ignored during LOCKOUT to protect the compressor from short cycling.
  always_comb begin
    state_next      = state;
    lock_next       = lock_cnt;
    compressor_next = compressor_on;
    case (state)
      OFF: begin
        if (req) begin
          state_next      = RUN;
          compressor_next = 1'b1;
        end
      end
      RUN: begin
        if (!req) begin
          state_next      = LOCKOUT;
          compressor_next = 1'b0;
          lock_next       = LOCK_LOAD;
        end
      end
      LOCKOUT: begin
        compressor_next = 1'b0;
        if (lock_cnt == '0) state_next = OFF;
        else                lock_next  = lock_cnt - LW'(1);
      end
      default: begin
        state_next      = OFF;
        compressor_next = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_ac_fan_driver.sv
// tb/tb_ac_fan_driver.sv - randomized and directed bench for ac_fan_driver against a timestamp model
module tb_ac_fan_driver;
  localparam int P = 100;
  localparam int R = 4;
  localparam int M = 200;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  ac_fan_driver_if bus ();

  ac_fan_driver #(.PWM_PERIOD(P), .RAMP_PERIODS(R), .MIN_OFF_CYCLES(M)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Model: edge index since reset, periods waited toward the next step,
  // and the timestamp of the last compressor fall.
  int  m_edge, m_spd, m_wait, m_fall, m_tgt;
  bit  m_pwm, m_comp, m_req;

  function automatic int clamp4(input int v);
    return (v > 4) ? 4 : v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_edge = 0; m_spd = 0; m_wait = 0; m_pwm = 0; m_comp = 0; m_fall = -100000;
    end else begin
      m_tgt = clamp4(int'(bus.fan_speed));
      m_req = (m_spd != 0) && (int'(bus.fan_heat) < int'(bus.temperature));
      m_pwm = (m_edge % P) < m_spd * (P / 4);
      if (m_comp && !m_req) begin
        m_comp = 0;
        m_fall = m_edge;
      end else if (!m_comp && m_req && m_edge >= m_fall + M + 1) begin
        m_comp = 1;
      end
      if (m_spd == m_tgt) m_wait = 0;
      else if (m_edge % P == P - 1) begin
        m_wait++;
        if (m_wait == R) begin
          m_wait = 0;
          m_spd += (m_tgt > m_spd) ? 1 : -1;
        end
      end
      m_edge++;
    end
  end

  always @(negedge clk) begin
    check("cyc_pwm", int'(bus.fan_pwm), reset ? int'(m_pwm) : 0);
    check("cyc_speed", int'(bus.speed_actual), reset ? m_spd : 0);
    check("cyc_comp", int'(bus.compressor_on), reset ? int'(m_comp) : 0);
    check("cyc_ramping", int'(bus.ramping),
          int'((reset ? m_spd : 0) != clamp4(int'(bus.fan_speed))));
  end

  task automatic wait_speed(input int lvl, input int limit, input string tag);
    for (int k = 0; k < limit && int'(bus.speed_actual) != lvl; k++) tick(1);
    check(tag, int'(bus.speed_actual), lvl);
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check({tag, "_pwm"}, int'(bus.fan_pwm), 0);
    check({tag, "_speed"}, int'(bus.speed_actual), 0);
    check({tag, "_comp"}, int'(bus.compressor_on), 0);
    tick(3);
  endtask

  task automatic step_timing(input int levels, input string tag);
    for (int lvl = 1; lvl <= levels; lvl++) begin
      tick(P * R - 1);
      check({tag, "_before"}, int'(bus.speed_actual), lvl - 1);
      tick(1);
      check({tag, "_step"}, int'(bus.speed_actual), lvl);
    end
  endtask

  initial begin
    int highs;
    bus.fan_speed = 3'd3; bus.fan_heat = 8'd255; bus.temperature = 7'd0;
    tick(3);
    check("rst_pwm", int'(bus.fan_pwm), 0);
    check("rst_speed", int'(bus.speed_actual), 0);
    check("rst_comp", int'(bus.compressor_on), 0);
    check("rst_ramping", int'(bus.ramping), 1);

    bus.fan_speed = 3'd4;
    reset = 1'b1;
    step_timing(4, "up");
    tick(2);
    check("full_pwm", int'(bus.fan_pwm), 1);
    check("full_ramping", int'(bus.ramping), 0);

    bus.fan_speed = 3'd7;
    tick(P * R + 5);
    check("clamp7", int'(bus.speed_actual), 4);

    bus.fan_speed = 3'd2;
    wait_speed(2, 1000, "down_to2");
    tick(P + 1);
    highs = 0;
    for (int k = 0; k < P; k++) begin
      highs += int'(bus.fan_pwm);
      tick(1);
    end
    check("duty50", highs, P / 2);

    bus.temperature = 7'd30; bus.fan_heat = 8'd25;
    tick(1);
    check("comp_rise", int'(bus.compressor_on), 1);
    bus.fan_heat = 8'd40;
    tick(1);
    check("comp_fall", int'(bus.compressor_on), 0);
    bus.fan_heat = 8'd25;
    tick(M);
    check("lockout_hold", int'(bus.compressor_on), 0);
    tick(1);
    check("lockout_rise", int'(bus.compressor_on), 1);

    bus.fan_speed = 3'd0;
    wait_speed(0, 1200, "ramp_to0");
    check("comp_at_speed0", int'(bus.compressor_on), 1);
    tick(1);
    check("comp_after_speed0", int'(bus.compressor_on), 0);
    tick(2);
    check("pwm_off", int'(bus.fan_pwm), 0);

    bus.fan_speed = 3'd4;
    wait_speed(4, 2000, "reup4");
    bus.fan_speed = 3'd0;
    wait_speed(2, 1000, "rev_at2");
    bus.fan_speed = 3'd3;
    wait_speed(3, 500, "rev_to3");
    tick(P * R * 2);
    check("rev_stays3", int'(bus.speed_actual), 3);
    check("rev_ramping", int'(bus.ramping), 0);

    bus.fan_speed = 3'd0;
    wait_speed(2, 500, "pre_reset2");
    async_reset_check("rst_midramp");
    bus.fan_speed = 3'd4;
    reset = 1'b1;
    tick(1);
    bus.fan_heat = 8'd25; bus.temperature = 7'd30;
    for (int k = 0; k < 1000 && !bus.compressor_on; k++) tick(1);
    check("relock_on", int'(bus.compressor_on), 1);
    bus.fan_heat = 8'd40;
    tick(50);
    async_reset_check("rst_lockout");
    bus.fan_speed = 3'd1;
    reset = 1'b1;
    step_timing(1, "after_rst");

    for (int it = 0; it < 25; it++) begin
      int hold;
      bus.fan_speed = 3'($urandom_range(0, 7));
      hold = $urandom_range(100, 1500);
      while (hold > 0) begin
        int chunk;
        bus.temperature = 7'($urandom_range(0, 127));
        bus.fan_heat = 8'($urandom_range(0, 140));
        chunk = $urandom_range(5, 300);
        tick(chunk);
        hold -= chunk;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
